// File: rtl/fp_exception_resolver.sv
// Resolves raw adder results against invalid/overflow flags into IEEE-754 special values,
// keeps sticky status and saturating event counters, and drives a maskable registered IRQ.
module fp_exception_resolver #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int DW = 1 + EXP_W + MAN_W,
  parameter logic [DW-1:0] QNAN = 32'h7FC0_0000,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_result,
  input  logic             in_invalid,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_result,
  output logic             out_invalid,
  output logic             out_overflow,
  output logic             sticky_inv,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] cnt_inv,
  output logic [CNT_W-1:0] cnt_ovf,
  input  logic             clr,
  input  logic [1:0]       irq_mask,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Invalid outranks overflow; overflow keeps the raw sign and forces an infinity.
  function automatic logic [DW-1:0] resolve(input logic [DW-1:0] raw,
                                            input logic inv, input logic ovf);
    logic [DW-1:0] res;
    if (inv) begin
      res = QNAN;
    end else if (ovf) begin
      res = {raw[DW-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      res = raw;
    end
    return res;
  endfunction

  // Event counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic ev);
    logic [CNT_W-1:0] nxt;
    if (ev && (cnt != CNT_MAX)) begin
      nxt = cnt + CNT_ONE;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  // A clear coinciding with an accept restarts the status from that accept's flags alone.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt, input logic ev,
                                               input logic acc, input logic clear);
    logic [CNT_W-1:0] nxt;
    if (acc && clear) begin
      nxt = ev ? CNT_ONE : {CNT_W{1'b0}};
    end else if (acc) begin
      nxt = sat_inc(cnt, ev);
    end else if (clear) begin
      nxt = {CNT_W{1'b0}};
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  function automatic logic sticky_next(input logic st, input logic ev,
                                       input logic acc, input logic clear);
    logic nxt;
    if (acc && clear) begin
      nxt = ev;
    end else if (acc) begin
      nxt = st | ev;
    end else if (clear) begin
      nxt = 1'b0;
    end else begin
      nxt = st;
    end
    return nxt;
  endfunction

  logic             out_valid_q,    out_valid_d;
  logic [DW-1:0]    out_result_q,   out_result_d;
  logic             out_invalid_q,  out_invalid_d;
  logic             out_overflow_q, out_overflow_d;
  logic             sticky_inv_q,   sticky_inv_d;
  logic             sticky_ovf_q,   sticky_ovf_d;
  logic [CNT_W-1:0] cnt_inv_q,      cnt_inv_d;
  logic [CNT_W-1:0] cnt_ovf_q,      cnt_ovf_d;
  logic             irq_q,          irq_d;
  logic             accept_s;

  assign in_ready = ~out_valid_q | out_ready;
  assign accept_s = in_valid & in_ready;

  // Next-state for the output stage, status flags, counters and interrupt.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_invalid_d  = out_invalid_q;
    out_overflow_d = out_overflow_q;

    if (accept_s) begin
      out_valid_d    = 1'b1;
      out_result_d   = resolve(in_result, in_invalid, in_overflow);
      out_invalid_d  = in_invalid;
      out_overflow_d = in_overflow;
    end else if (out_ready) begin
      out_valid_d    = 1'b0;
    end else begin
      out_valid_d    = out_valid_q;
    end

    sticky_inv_d = sticky_next(sticky_inv_q, in_invalid, accept_s, clr);
    sticky_ovf_d = sticky_next(sticky_ovf_q, in_overflow, accept_s, clr);
    cnt_inv_d    = cnt_next(cnt_inv_q, in_invalid, accept_s, clr);
    cnt_ovf_d    = cnt_next(cnt_ovf_q, in_overflow, accept_s, clr);

    // Uses next-state sticky bits so the IRQ rises on the same edge as the status.
    irq_d = (sticky_inv_d & irq_mask[0]) | (sticky_ovf_d & irq_mask[1]);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_result_q   <= {DW{1'b0}};
      out_invalid_q  <= 1'b0;
      out_overflow_q <= 1'b0;
      sticky_inv_q   <= 1'b0;
      sticky_ovf_q   <= 1'b0;
      cnt_inv_q      <= {CNT_W{1'b0}};
      cnt_ovf_q      <= {CNT_W{1'b0}};
      irq_q          <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_invalid_q  <= out_invalid_d;
      out_overflow_q <= out_overflow_d;
      sticky_inv_q   <= sticky_inv_d;
      sticky_ovf_q   <= sticky_ovf_d;
      cnt_inv_q      <= cnt_inv_d;
      cnt_ovf_q      <= cnt_ovf_d;
      irq_q          <= irq_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_invalid  = out_invalid_q;
  assign out_overflow = out_overflow_q;
  assign sticky_inv   = sticky_inv_q;
  assign sticky_ovf   = sticky_ovf_q;
  assign cnt_inv      = cnt_inv_q;
  assign cnt_ovf      = cnt_ovf_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_fp_exception_resolver.sv
// Directed, table-driven bench for fp_exception_resolver with hand-computed expectations.
module tb_fp_exception_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic        in_invalid, in_overflow;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_invalid, out_overflow;
  logic        sticky_inv, sticky_ovf;
  logic [7:0]  cnt_inv, cnt_ovf;
  logic        clr;
  logic [1:0]  irq_mask;
  logic        irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_exception_resolver dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_invalid(in_invalid), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_invalid(out_invalid), .out_overflow(out_overflow),
    .sticky_inv(sticky_inv), .sticky_ovf(sticky_ovf),
    .cnt_inv(cnt_inv), .cnt_ovf(cnt_ovf),
    .clr(clr), .irq_mask(irq_mask), .irq(irq)
  );

  typedef struct {
    logic        vld;
    logic [31:0] res;
    logic        inv;
    logic        ovf;
    logic        ordy;
    logic        clr;
    logic [1:0]  mask;
    logic        e_ov;
    logic [31:0] e_res;
    logic        e_inv;
    logic        e_ovf;
    logic        e_si;
    logic        e_so;
    logic [7:0]  e_ci;
    logic [7:0]  e_co;
    logic        e_irq;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic i, input logic o,
                       input logic ordy, input logic c, input logic [1:0] m);
    in_valid = v; in_result = r; in_invalid = i; in_overflow = o;
    out_ready = ordy; clr = c; irq_mask = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 32'h7F80_0001, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);

    // T1: reset held two cycles with valid input present
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_flags", {28'd0, out_invalid, out_overflow, sticky_inv, sticky_ovf}, 32'd0);
    chk("rst_cnt", {16'd0, cnt_inv, cnt_ovf}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    tick();

    // T2/T3 and status accumulation, one vector per cycle with out_ready=1
    vecs[0] = '{1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0};
    vecs[1] = '{1'b1, 32'h7F80_0001, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00,
                1'b1, 32'h7FC0_0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0};
    vecs[2] = '{1'b1, 32'hC000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00,
                1'b1, 32'hFF80_0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 8'd1, 1'b0};
    vecs[3] = '{1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00,
                1'b1, 32'h7FC0_0000, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 8'd2, 1'b0};
    vecs[4] = '{1'b1, 32'h7F7F_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00,
                1'b1, 32'h7F80_0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 8'd3, 1'b0};
    vecs[5] = '{1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00,
                1'b0, 32'h7F80_0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 8'd3, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00,
                1'b0, 32'h7F80_0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0};
    vecs[7] = '{1'b1, 32'h4049_0FDB, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00,
                1'b1, 32'h7FC0_0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0};
    vecs[8] = '{1'b1, 32'h3F80_0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01,
                1'b1, 32'h7F80_0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 8'd1, 1'b1};

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].vld, vecs[i].res, vecs[i].inv, vecs[i].ovf,
            vecs[i].ordy, vecs[i].clr, vecs[i].mask);
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("v%0d_result", i), out_result, vecs[i].e_res);
      chk($sformatf("v%0d_flags", i), {30'd0, out_invalid, out_overflow},
          {30'd0, vecs[i].e_inv, vecs[i].e_ovf});
      chk($sformatf("v%0d_sticky", i), {30'd0, sticky_inv, sticky_ovf},
          {30'd0, vecs[i].e_si, vecs[i].e_so});
      chk($sformatf("v%0d_cnt", i), {16'd0, cnt_inv, cnt_ovf},
          {16'd0, vecs[i].e_ci, vecs[i].e_co});
      chk($sformatf("v%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].e_irq});
    end

    // T4: backpressure, only one item accepted while out_ready=0
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    tick();
    drive(1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_first_result", out_result, 32'h7FC0_0000);
    drive(1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    #1;
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_hold%0d_result", k), out_result, 32'h7FC0_0000);
      chk($sformatf("bp_hold%0d_valid", k), {31'd0, out_valid}, 32'd1);
    end
    chk("bp_one_accept", {24'd0, cnt_inv}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_b2b_0", out_result, 32'h2222_2222);
    drive(1'b1, 32'h3333_3333, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    chk("bp_b2b_1", out_result, 32'h3333_3333);
    chk("bp_b2b_1_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    tick();
    chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);

    // T5: overflow counter saturation and clear behaviour
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    tick();
    drive(1'b1, 32'h7F00_0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    for (int k = 0; k < 300; k++) tick();
    chk("sat_cnt_ovf", {24'd0, cnt_ovf}, 32'd255);
    chk("sat_cnt_inv", {24'd0, cnt_inv}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    tick();
    chk("clr_cnt_ovf", {24'd0, cnt_ovf}, 32'd0);
    chk("clr_sticky_ovf", {31'd0, sticky_ovf}, 32'd0);
    drive(1'b1, 32'h7F00_0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    tick();
    tick();
    drive(1'b1, 32'h7F00_0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    tick();
    chk("clr_acc_cnt_ovf", {24'd0, cnt_ovf}, 32'd1);
    chk("clr_acc_sticky_ovf", {31'd0, sticky_ovf}, 32'd1);

    // T6: masked interrupt
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
    tick();
    drive(1'b1, 32'h7F00_0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01);
    tick();
    chk("irq_ovf_masked", {31'd0, irq}, 32'd0);
    drive(1'b1, 32'h7F80_0001, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
    tick();
    chk("irq_inv_set", {31'd0, irq}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
    tick();
    chk("irq_clr", {31'd0, irq}, 32'd0);

    // Reset mid-transfer drops the held result
    drive(1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    chk("midrst_pre", out_result, 32'h5555_5555);
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", out_result, 32'd0);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
